one_hot_encoder: RTL and testbench

Converts a binary target index into a registered one-hot select strobe, holds it for a programmable number of cycles, then waits for the addressed target's acknowledge. Sits on the dispatch side of the datapath, opposite `one_hot_decoder`: the decoder compresses one-hot requests to an index, and this block expands an index back into a per-target select under a valid/ready handshake.

---
 rtl/one_hot_encoder.sv | 119 +++++++++++
 tb/tb_one_hot_encoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/one_hot_encoder.sv
// Index-to-one-hot select strobe with programmable hold and per-target ack.
// Optional ack timeout: define ONE_HOT_ENCODER_TIMEOUT_EN.
module one_hot_encoder #(
    parameter int OUTPUT_WIDTH = 16,
    parameter int INPUT_WIDTH  = (OUTPUT_WIDTH > 1) ? $clog2(OUTPUT_WIDTH) : 1,
    parameter int HOLD_WIDTH   = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [INPUT_WIDTH-1:0]  A,
    input  logic [HOLD_WIDTH-1:0]   HOLD,
    output logic [OUTPUT_WIDTH-1:0] B,
    output logic                    ANY,
    input  logic [OUTPUT_WIDTH-1:0] ACK,
    output logic                    DONE,
    output logic                    ERR
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [INPUT_WIDTH:0]  NUM_TGT = (INPUT_WIDTH + 1)'(OUTPUT_WIDTH);
    localparam logic [HOLD_WIDTH-1:0] CNT_ONE = HOLD_WIDTH'(1);

    logic [1:0]              state;
    logic [INPUT_WIDTH-1:0]  idx;
    logic [HOLD_WIDTH-1:0]   cnt;
    logic                    ack_seen;
    logic [OUTPUT_WIDTH-1:0] b_q;
    logic                    done_q;
    logic                    err_q;

    logic                    in_range;
    logic                    ack_hit;
    logic [HOLD_WIDTH-1:0]   hold_eff;

`ifdef ONE_HOT_ENCODER_TIMEOUT_EN
    localparam int           TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    logic [TW-1:0]           tmo;
`endif

    assign in_range = {1'b0, A} < NUM_TGT;
    assign ack_hit  = ACK[idx];
    assign hold_eff = (HOLD == '0) ? CNT_ONE : HOLD;

    assign IN_READY = (state == S_IDLE) & ~RST;
    assign B        = b_q;
    assign ANY      = |b_q;
    assign DONE     = done_q;
    assign ERR      = err_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            idx      <= '0;
            cnt      <= '0;
            ack_seen <= 1'b0;
            b_q      <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef ONE_HOT_ENCODER_TIMEOUT_EN
            tmo      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (IN_VALID) begin
                        idx      <= A;
                        cnt      <= hold_eff;
                        ack_seen <= 1'b0;
                        if (in_range) begin
                            state <= S_DRIVE;
                            b_q   <= OUTPUT_WIDTH'(1) << A;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_DRIVE: begin
                    if (ack_hit) ack_seen <= 1'b1;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= S_WAIT;
                        b_q   <= '0;
`ifdef ONE_HOT_ENCODER_TIMEOUT_EN
                        tmo   <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    // an ack on the last allowed cycle beats the timeout
                    if (ack_seen | ack_hit) begin
                        ack_seen <= 1'b1;
                        state    <= S_IDLE;
                        done_q   <= 1'b1;
                    end
`ifdef ONE_HOT_ENCODER_TIMEOUT_EN
                    else if (tmo == TMO_LAST) begin
                        state <= S_IDLE;
                        err_q <= 1'b1;
                    end else begin
                        tmo <= tmo + TMO_ONE;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_one_hot_encoder.sv
// Scoreboard bench for one_hot_encoder: random transactions vs a timing model.
`timescale 1ns/1ps
module tb_one_hot_encoder;

    localparam int OW = 10;
    localparam int IW = 4;
    localparam int HW = 4;
    localparam int TO = 10;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [IW-1:0] A = '0;
    logic [HW-1:0] HOLD = '0;
    logic [OW-1:0] B;
    logic          ANY;
    logic [OW-1:0] ACK = '0;
    logic          DONE;
    logic          ERR;

    one_hot_encoder #(
        .OUTPUT_WIDTH(OW), .INPUT_WIDTH(IW), .HOLD_WIDTH(HW), .TIMEOUT(TO)
    ) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .HOLD(HOLD), .B(B), .ANY(ANY), .ACK(ACK),
        .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit            err;
        int            cyc;
        logic [OW-1:0] b;
        int            h;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [OW-1:0] noise(input int a, input bit hit);
        logic [OW-1:0] n;
        logic [OW-1:0] m;
        n = OW'($urandom);
        if (a < OW) begin
            m = OW'(1) << a;
            n = hit ? (n | m) : (n & ~m);
        end
        return n;
    endfunction

    // Monitor: strobe shape is accumulated, then judged at each DONE/ERR pulse.
    int            sn = 0;
    logic [OW-1:0] sb = '0;
    bit            sbad = 1'b0;
    exp_t          e;
    always @(negedge CLK) begin
        if (RST) begin
            sn   = 0;
            sbad = 1'b0;
        end else begin
            chk("any", ANY, B != '0);
            if (B != '0) begin
                if (sn == 0) sb = B;
                else if (B !== sb) sbad = 1'b1;
                sn++;
            end
            if (DONE || ERR) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_pulse", {DONE, ERR}, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("done_err", {DONE, ERR}, e.err ? 1 : 2);
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("strobe_len", sn, e.h);
                    if (e.h > 0) begin
                        chk("strobe_val", sb, e.b);
                        chk("strobe_stable", sbad, 0);
                    end
                end
                sn   = 0;
                sbad = 1'b0;
            end
        end
    end

    // Called at a negedge where the DUT should be idle; returns at the
    // negedge of the DONE/ERR cycle so the next accept can be back-to-back.
    task automatic txn(input int a, input int h, input int k, input bit hold_ack);
        int   hh;
        int   ec;
        exp_t x;
        hh = (h == 0) ? 1 : h;
        if (a >= OW) begin
            x.err = 1'b1;
            ec    = 1;
        end else begin
            x.err = 1'b0;
            ec    = (k <= hh + 1) ? hh + 2 : k + 1;
`ifdef ONE_HOT_ENCODER_TIMEOUT_EN
            if (k > hh + TO) begin
                x.err = 1'b1;
                ec    = hh + TO + 1;
            end
`endif
        end
        x.cyc = cyc + ec;
        x.b   = (a < OW) ? (OW'(1) << a) : '0;
        x.h   = (a < OW) ? hh : 0;
        chk("ready_idle", IN_READY, 1);
        sbq.push_back(x);
        IN_VALID = 1'b1;
        A        = IW'(a);
        HOLD     = HW'(h);
        ACK      = noise(a, 1'($urandom));
        for (int j = 1; j < ec; j++) begin
            @(negedge CLK);
            chk("ready_busy", IN_READY, 0);
            IN_VALID = 1'($urandom);
            A        = IW'($urandom);
            HOLD     = HW'($urandom);
            ACK      = noise(a, (j == k) || (hold_ack && j >= k));
        end
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    initial begin
        int a;
        int h;
        int k;
        int span;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_b", B, 0);
        chk("rst_any", ANY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err", ERR, 0);
        chk("rst_ready", IN_READY, 0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        txn(5, 3, 1, 1'b1);
        txn(0, 0, 7, 1'b0);
        txn(12, 2, 1, 1'b0);
        txn(9, 1, 2, 1'b0);
        txn(7, 4, 2, 1'b0);

        // reset in cycle 2 of a long strobe
        chk("ready_pre_rst", IN_READY, 1);
        IN_VALID = 1'b1;
        A        = IW'(3);
        HOLD     = HW'(8);
        ACK      = '0;
        @(negedge CLK);
        IN_VALID = 1'b0;
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("midrst_b", B, 0);
        chk("midrst_any", ANY, 0);
        chk("midrst_ready", IN_READY, 0);
        @(negedge CLK);
        #2 RST = 1'b0;
        repeat (4) @(negedge CLK);
        txn(4, 2, 3, 1'b0);

        txn(2, 1, 41, 1'b0);

        for (int n = 0; n < 200; n++) begin
            a = ($urandom_range(0, 15) == 0) ? 15 : int'($urandom_range(0, 11));
            h = $urandom_range(0, 15);
`ifdef ONE_HOT_ENCODER_TIMEOUT_EN
            span = TO + 3;
`else
            span = 6;
`endif
            k = $urandom_range(1, ((h == 0) ? 1 : h) + span);
            txn(a, h, k, 1'($urandom));
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) @(negedge CLK);
        end

        repeat (5) @(negedge CLK);
        chk("queue_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
